// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard scoreboard interface: ID/EX/WB hazard inputs from the pipeline and
// the stall/flush/scoreboard outputs returned to it. The pipeline side is the
// master, the hazard unit is the slave.
interface hazard_scoreboard_unit_if #(
   parameter int REG_ADDR_W      = 5,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STALL_CNT_W     = 16
);
   localparam int NUM_REGS = 2 ** REG_ADDR_W;
   localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

   logic [REG_ADDR_W-1:0]  i_if_id_rs1;
   logic [REG_ADDR_W-1:0]  i_if_id_rs2;
   logic                   i_if_id_uses_rs1;
   logic                   i_if_id_uses_rs2;
   logic [REG_ADDR_W-1:0]  i_if_id_rd;
   logic                   i_if_id_is_long;
   logic [REG_ADDR_W-1:0]  i_id_ex_rd;
   logic                   i_id_ex_mem_read;
   logic                   i_ex_long_issue;
   logic                   i_wb_long_valid;
   logic [REG_ADDR_W-1:0]  i_wb_long_rd;
   logic                   i_ex_branch_taken;
   logic                   i_stall_cnt_clr;
   logic                   o_pc_write;
   logic                   o_if_id_write;
   logic                   o_control_stall;
   logic                   o_if_id_flush;
   logic                   o_id_ex_flush;
   logic [NUM_REGS-1:0]    o_busy_regs;
   logic [OUT_W-1:0]       o_outstanding;
   logic [STALL_CNT_W-1:0] o_stall_count;

   modport master (
      output i_if_id_rs1, i_if_id_rs2, i_if_id_uses_rs1, i_if_id_uses_rs2,
             i_if_id_rd, i_if_id_is_long, i_id_ex_rd, i_id_ex_mem_read,
             i_ex_long_issue, i_wb_long_valid, i_wb_long_rd,
             i_ex_branch_taken, i_stall_cnt_clr,
      input  o_pc_write, o_if_id_write, o_control_stall, o_if_id_flush,
             o_id_ex_flush, o_busy_regs, o_outstanding, o_stall_count
   );

   modport slave (
      input  i_if_id_rs1, i_if_id_rs2, i_if_id_uses_rs1, i_if_id_uses_rs2,
             i_if_id_rd, i_if_id_is_long, i_id_ex_rd, i_id_ex_mem_read,
             i_ex_long_issue, i_wb_long_valid, i_wb_long_rd,
             i_ex_branch_taken, i_stall_cnt_clr,
      output o_pc_write, o_if_id_write, o_control_stall, o_if_id_flush,
             o_id_ex_flush, o_busy_regs, o_outstanding, o_stall_count
   );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: ID-stage hazard control. Combines classic load-use
// detection with a per-register busy scoreboard for variable-latency ops,
// WAW and outstanding-op limits, taken-branch flush and a saturating stall
// counter. With SB_EN=0 only load-use detection and branch flush remain.
module hazard_scoreboard_unit #(
   parameter int REG_ADDR_W      = 5,
   parameter bit SB_EN           = 1'b1,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STALL_CNT_W     = 16
) (
   input logic                     i_clk,
   input logic                     i_rst_n,
   hazard_scoreboard_unit_if.slave hz
);
   localparam int NUM_REGS = 2 ** REG_ADDR_W;
   localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [REG_ADDR_W-1:0]  REG_X0   = {REG_ADDR_W{1'b0}};
   localparam logic [OUT_W-1:0]       OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
   localparam logic [STALL_CNT_W-1:0] CNT_MAX  = {STALL_CNT_W{1'b1}};
   localparam logic [STALL_CNT_W-1:0] CNT_ONE  = STALL_CNT_W'(1'b1);
   localparam logic [STALL_CNT_W-1:0] CNT_ZERO = {STALL_CNT_W{1'b0}};

   // Number of set bits in a busy vector (ops that still own a register).
   function automatic int count_ones(input logic [NUM_REGS-1:0] vec);
      int n;
      n = 32'sd0;
      for (int i = 0; i < NUM_REGS; i++) begin
         n += int'(vec[i]);
      end
      return n;
   endfunction

   logic [NUM_REGS-1:0]    busy_r;
   logic [NUM_REGS-1:0]    busy_next_s;
   logic [NUM_REGS-1:0]    eff_busy_s;
   logic [OUT_W-1:0]       outstanding_r;
   logic [OUT_W-1:0]       next_out_s;
   logic [STALL_CNT_W-1:0] stall_cnt_r;
   int                     next_out_int_s;
   logic                   src1_s;
   logic                   src2_s;
   logic                   issue_s;
   logic                   retire_s;
   logic                   load_use_s;
   logic                   raw_s;
   logic                   waw_s;
   logic                   struct_haz_s;
   logic                   stall_s;

   // Hazard detection: load-use, scoreboard RAW/WAW and outstanding limit.
   always_comb begin
      src1_s  = hz.i_if_id_uses_rs1 && (hz.i_if_id_rs1 != REG_X0);
      src2_s  = hz.i_if_id_uses_rs2 && (hz.i_if_id_rs2 != REG_X0);
      issue_s = SB_EN && hz.i_ex_long_issue;

      load_use_s = hz.i_id_ex_mem_read && (hz.i_id_ex_rd != REG_X0) &&
                   ((src1_s && (hz.i_if_id_rs1 == hz.i_id_ex_rd)) ||
                    (src2_s && (hz.i_if_id_rs2 == hz.i_id_ex_rd)));

      // An op issuing this cycle already owns its rd; a WB this cycle is
      // forwarded, so its register is no longer a hazard.
      for (int r = 0; r < NUM_REGS; r++) begin
         eff_busy_s[r] = (busy_r[r] ||
                          (issue_s && (hz.i_id_ex_rd == REG_ADDR_W'(r)) && (r != 0))) &&
                         !(hz.i_wb_long_valid && (hz.i_wb_long_rd == REG_ADDR_W'(r)));
      end

      // rd==0 ops have no busy bit; they retire only if the count exceeds
      // the ops that still hold a busy bit.
      if (!SB_EN || !hz.i_wb_long_valid) begin
         retire_s = 1'b0;
      end else if (hz.i_wb_long_rd != REG_X0) begin
         retire_s = busy_r[hz.i_wb_long_rd];
      end else begin
         retire_s = int'(outstanding_r) > count_ones(busy_r);
      end

      next_out_int_s = int'(outstanding_r) + int'(issue_s) - int'(retire_s);
      if (next_out_int_s < 32'sd0) begin
         next_out_int_s = 32'sd0;
      end else if (next_out_int_s > MAX_OUTSTANDING) begin
         next_out_int_s = MAX_OUTSTANDING;
      end else begin
         next_out_int_s = next_out_int_s;
      end
      next_out_s = OUT_W'(next_out_int_s);

      raw_s = SB_EN && ((src1_s && eff_busy_s[hz.i_if_id_rs1]) ||
                        (src2_s && eff_busy_s[hz.i_if_id_rs2]));
      waw_s = SB_EN && hz.i_if_id_is_long && (hz.i_if_id_rd != REG_X0) &&
              eff_busy_s[hz.i_if_id_rd];
      struct_haz_s = SB_EN && hz.i_if_id_is_long && (next_out_s >= OUT_MAX);
      stall_s = load_use_s || raw_s || waw_s || struct_haz_s;
   end

   // Next busy vector: clear on writeback, then set on issue so set wins.
   always_comb begin
      busy_next_s = busy_r;
      if (SB_EN && hz.i_wb_long_valid) begin
         busy_next_s[hz.i_wb_long_rd] = 1'b0;
      end else begin
         busy_next_s = busy_next_s;
      end
      if (issue_s) begin
         busy_next_s[hz.i_id_ex_rd] = 1'b1;
      end else begin
         busy_next_s = busy_next_s;
      end
      busy_next_s[0] = 1'b0;
   end

   // Pipeline control: reset holds the pipe, flush overrides stall.
   always_comb begin
      if (!i_rst_n) begin
         hz.o_pc_write      = 1'b0;
         hz.o_if_id_write   = 1'b0;
         hz.o_control_stall = 1'b1;
         hz.o_if_id_flush   = 1'b0;
         hz.o_id_ex_flush   = 1'b0;
      end else if (hz.i_ex_branch_taken) begin
         hz.o_pc_write      = 1'b1;
         hz.o_if_id_write   = 1'b1;
         hz.o_control_stall = 1'b1;
         hz.o_if_id_flush   = 1'b1;
         hz.o_id_ex_flush   = 1'b1;
      end else begin
         hz.o_pc_write      = !stall_s;
         hz.o_if_id_write   = !stall_s;
         hz.o_control_stall = stall_s;
         hz.o_if_id_flush   = 1'b0;
         hz.o_id_ex_flush   = 1'b0;
      end
   end

   // Scoreboard state: busy bits and in-flight long-op count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_r        <= {NUM_REGS{1'b0}};
         outstanding_r <= {OUT_W{1'b0}};
      end else begin
         busy_r        <= busy_next_s;
         outstanding_r <= next_out_s;
      end
   end

   // Saturating stall-cycle counter; clear beats increment.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_r <= CNT_ZERO;
      end else if (hz.i_stall_cnt_clr) begin
         stall_cnt_r <= CNT_ZERO;
      end else if (stall_s && !hz.i_ex_branch_taken && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign hz.o_busy_regs   = busy_r;
   assign hz.o_outstanding = outstanding_r;
   assign hz.o_stall_count = stall_cnt_r;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances share one stimulus stream,
// dut_a with the scoreboard (16-bit counter) and dut_b without it (2-bit
// counter). Table vectors, directed multi-cycle sequences and random cycles
// are all compared against a reference model built from the hazard rules.
module tb_hazard_scoreboard_unit;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .MAX_OUTSTANDING(4), .STALL_CNT_W(16)) if_a ();
   hazard_scoreboard_unit_if #(.REG_ADDR_W(5), .MAX_OUTSTANDING(4), .STALL_CNT_W(2))  if_b ();

   hazard_scoreboard_unit #(.REG_ADDR_W(5), .SB_EN(1'b1), .MAX_OUTSTANDING(4), .STALL_CNT_W(16))
      dut_a (.i_clk(clk), .i_rst_n(rst_n), .hz(if_a));
   hazard_scoreboard_unit #(.REG_ADDR_W(5), .SB_EN(1'b0), .MAX_OUTSTANDING(4), .STALL_CNT_W(2))
      dut_b (.i_clk(clk), .i_rst_n(rst_n), .hz(if_b));

   assign if_b.i_if_id_rs1       = if_a.i_if_id_rs1;
   assign if_b.i_if_id_rs2       = if_a.i_if_id_rs2;
   assign if_b.i_if_id_uses_rs1  = if_a.i_if_id_uses_rs1;
   assign if_b.i_if_id_uses_rs2  = if_a.i_if_id_uses_rs2;
   assign if_b.i_if_id_rd        = if_a.i_if_id_rd;
   assign if_b.i_if_id_is_long   = if_a.i_if_id_is_long;
   assign if_b.i_id_ex_rd        = if_a.i_id_ex_rd;
   assign if_b.i_id_ex_mem_read  = if_a.i_id_ex_mem_read;
   assign if_b.i_ex_long_issue   = if_a.i_ex_long_issue;
   assign if_b.i_wb_long_valid   = if_a.i_wb_long_valid;
   assign if_b.i_wb_long_rd      = if_a.i_wb_long_rd;
   assign if_b.i_ex_branch_taken = if_a.i_ex_branch_taken;
   assign if_b.i_stall_cnt_clr   = if_a.i_stall_cnt_clr;

   logic [4:0] ctl_a, ctl_b;
   assign ctl_a = {if_a.o_pc_write, if_a.o_if_id_write, if_a.o_control_stall,
                   if_a.o_if_id_flush, if_a.o_id_ex_flush};
   assign ctl_b = {if_b.o_pc_write, if_b.o_if_id_write, if_b.o_control_stall,
                   if_b.o_if_id_flush, if_b.o_id_ex_flush};

   typedef struct {
      logic [4:0] rs1, rs2, rd, ex_rd, wb_rd;
      logic       u1, u2, is_long, mem_read, issue, wb, br, clr;
   } in_t;
   typedef struct {
      in_t        in;
      logic [4:0] ctl;
   } vec_t;

   in_t  cur;
   vec_t tbl[$];
   bit   m_busy [32];
   int   m_out, m_cnt_a, m_cnt_b;
   int   checks   = 0;
   int   failures = 0;

   localparam logic [4:0] CTL_RUN   = 5'b11000;
   localparam logic [4:0] CTL_STALL = 5'b00100;
   localparam logic [4:0] CTL_FLUSH = 5'b11111;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic in_t idle_in();
      in_t t;
      t.rs1 = 5'd0; t.rs2 = 5'd0; t.rd = 5'd0; t.ex_rd = 5'd0; t.wb_rd = 5'd0;
      t.u1 = 1'b0; t.u2 = 1'b0; t.is_long = 1'b0; t.mem_read = 1'b0;
      t.issue = 1'b0; t.wb = 1'b0; t.br = 1'b0; t.clr = 1'b0;
      return t;
   endfunction

   function automatic in_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic [4:0] ex_rd, input logic mem,
                              input logic br, input logic clr);
      in_t t;
      t = idle_in();
      t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
      t.ex_rd = ex_rd; t.mem_read = mem; t.br = br; t.clr = clr;
      return t;
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] busy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   function automatic int busy_count();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic bit eff(input int r);
      return (m_busy[r] || (cur.issue && int'(cur.ex_rd) == r)) && r != 0 &&
             !(cur.wb && int'(cur.wb_rd) == r);
   endfunction

   function automatic bit retires();
      if (!cur.wb) return 1'b0;
      if (cur.wb_rd != 5'd0) return m_busy[cur.wb_rd];
      return m_out > busy_count();
   endfunction

   function automatic int next_out();
      int n = m_out + int'(cur.issue) - int'(retires());
      if (n < 0) n = 0;
      if (n > 4) n = 4;
      return n;
   endfunction

   function automatic bit model_stall(input bit sb);
      bit s1, s2, lu, raw, waw, st;
      s1 = cur.u1 && cur.rs1 != 5'd0;
      s2 = cur.u2 && cur.rs2 != 5'd0;
      lu = cur.mem_read && cur.ex_rd != 5'd0 &&
           ((s1 && cur.rs1 == cur.ex_rd) || (s2 && cur.rs2 == cur.ex_rd));
      if (!sb) return lu;
      raw = (s1 && eff(int'(cur.rs1))) || (s2 && eff(int'(cur.rs2)));
      waw = cur.is_long && cur.rd != 5'd0 && eff(int'(cur.rd));
      st  = cur.is_long && next_out() >= 4;
      return lu || raw || waw || st;
   endfunction

   function automatic logic [4:0] model_ctl(input bit sb);
      if (cur.br) return CTL_FLUSH;
      return model_stall(sb) ? CTL_STALL : CTL_RUN;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_out = 0; m_cnt_a = 0; m_cnt_b = 0;
   endfunction

   function automatic void model_update();
      bit sa, sbb;
      int n;
      sa  = model_stall(1'b1);
      sbb = model_stall(1'b0);
      n   = next_out();
      if (cur.wb && cur.wb_rd != 5'd0) m_busy[cur.wb_rd] = 1'b0;
      if (cur.issue && cur.ex_rd != 5'd0) m_busy[cur.ex_rd] = 1'b1;
      m_out = n;
      if (cur.clr) m_cnt_a = 0;
      else if (sa && !cur.br && m_cnt_a < 65535) m_cnt_a++;
      if (cur.clr) m_cnt_b = 0;
      else if (sbb && !cur.br && m_cnt_b < 3) m_cnt_b++;
   endfunction

   // ---------------- cycle helpers ----------------
   task automatic drive();
      if_a.i_if_id_rs1       = cur.rs1;
      if_a.i_if_id_rs2       = cur.rs2;
      if_a.i_if_id_uses_rs1  = cur.u1;
      if_a.i_if_id_uses_rs2  = cur.u2;
      if_a.i_if_id_rd        = cur.rd;
      if_a.i_if_id_is_long   = cur.is_long;
      if_a.i_id_ex_rd        = cur.ex_rd;
      if_a.i_id_ex_mem_read  = cur.mem_read;
      if_a.i_ex_long_issue   = cur.issue;
      if_a.i_wb_long_valid   = cur.wb;
      if_a.i_wb_long_rd      = cur.wb_rd;
      if_a.i_ex_branch_taken = cur.br;
      if_a.i_stall_cnt_clr   = cur.clr;
   endtask

   task automatic compare_all();
      logic [4:0] ea, eb;
      if (rst_n) begin
         ea = model_ctl(1'b1);
         eb = model_ctl(1'b0);
      end else begin
         ea = CTL_STALL;
         eb = CTL_STALL;
      end
      check("ctl_a",  32'(ctl_a), 32'(ea));
      check("busy_a", if_a.o_busy_regs, busy_vec());
      check("out_a",  32'(if_a.o_outstanding), m_out);
      check("cnt_a",  32'(if_a.o_stall_count), m_cnt_a);
      check("ctl_b",  32'(ctl_b), 32'(eb));
      check("busy_b", if_b.o_busy_regs, 32'd0);
      check("out_b",  32'(if_b.o_outstanding), 32'd0);
      check("cnt_b",  32'(if_b.o_stall_count), m_cnt_b);
   endtask

   task automatic begin_cycle();
      @(negedge clk);
      drive();
      #1;
      compare_all();
   endtask

   task automatic end_cycle();
      @(posedge clk);
      if (rst_n) model_update();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cur = idle_in();
      drive();
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      in_t t;
      cur = idle_in();
      drive();
      model_reset();
      do_reset();

      // ---- table-driven single-cycle vectors from a clean scoreboard ----
      tbl.push_back('{mk(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0), CTL_RUN});
      tbl.push_back('{mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0), CTL_STALL});
      tbl.push_back('{mk(5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0), CTL_STALL});
      tbl.push_back('{mk(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), CTL_RUN});
      tbl.push_back('{mk(5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0), CTL_RUN});
      tbl.push_back('{mk(5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0), CTL_RUN});
      tbl.push_back('{mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), CTL_FLUSH});
      tbl.push_back('{mk(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0), CTL_FLUSH});
      tbl.push_back('{mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1), CTL_STALL});
      tbl.push_back('{mk(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), CTL_STALL});
      t = mk(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      t.is_long = 1'b1; t.rd = 5'd9;
      tbl.push_back('{t, CTL_RUN});
      foreach (tbl[i]) begin
         cur = tbl[i].in;
         begin_cycle();
         check("tbl_ctl_a", 32'(ctl_a), 32'(tbl[i].ctl));
         check("tbl_ctl_b", 32'(ctl_b), 32'(tbl[i].ctl));
         end_cycle();
      end

      // ---- load-use then branch over load-use: flush wins, count holds ----
      do_reset();
      cur = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      begin_cycle();
      check("lu_ctl", 32'(ctl_a), 32'(CTL_STALL));
      end_cycle();
      cur.br = 1'b1;
      begin_cycle();
      check("flush_ctl_a", 32'(ctl_a), 32'(CTL_FLUSH));
      check("flush_ctl_b", 32'(ctl_b), 32'(CTL_FLUSH));
      check("lu_count", 32'(if_a.o_stall_count), 32'd1);
      end_cycle();
      cur = idle_in();
      begin_cycle();
      check("flush_count_a", 32'(if_a.o_stall_count), 32'd1);
      check("flush_count_b", 32'(if_b.o_stall_count), 32'd1);
      end_cycle();

      // ---- long RAW: issue rd=7 at k=0, WB at k=6 ----
      do_reset();
      for (int k = 0; k < 8; k++) begin
         cur = idle_in();
         cur.rs2 = 5'd7; cur.u2 = 1'b1; cur.rs1 = 5'd7; cur.u1 = (k == 7);
         if (k == 0) begin cur.issue = 1'b1; cur.ex_rd = 5'd7; end
         if (k == 6) begin cur.wb = 1'b1; cur.wb_rd = 5'd7; end
         begin_cycle();
         check("raw_stall", 32'(if_a.o_control_stall), 32'(k <= 5));
         check("raw_busy7", 32'(if_a.o_busy_regs[7]), 32'(k >= 1 && k <= 6));
         check("nosb_stall", 32'(if_b.o_control_stall), 32'd0);
         end_cycle();
      end

      // ---- structural: four outstanding ops, then one retires ----
      do_reset();
      for (int k = 0; k < 7; k++) begin
         cur = idle_in();
         if (k < 4) begin cur.issue = 1'b1; cur.ex_rd = 5'(k + 1); end
         if (k == 4 || k == 5) begin cur.is_long = 1'b1; cur.rd = 5'd9; end
         if (k == 5) begin cur.wb = 1'b1; cur.wb_rd = 5'd2; end
         begin_cycle();
         if (k == 4) begin
            check("struct_stall", 32'(if_a.o_control_stall), 32'd1);
            check("struct_out4", 32'(if_a.o_outstanding), 32'd4);
         end
         if (k == 5) check("struct_release", 32'(ctl_a), 32'(CTL_RUN));
         if (k == 6) check("struct_out3", 32'(if_a.o_outstanding), 32'd3);
         end_cycle();
      end

      // ---- saturation and asynchronous reset in mid-stall ----
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cur = mk(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
         if (k == 0) begin cur.rs1 = 5'd7; cur.ex_rd = 5'd7; cur.issue = 1'b1; end
         begin_cycle();
         if (k < 5) end_cycle();
      end
      check("sat_cnt_b", 32'(if_b.o_stall_count), 32'd3);
      check("sat_cnt_a", 32'(if_a.o_stall_count), 32'd5);
      check("sat_busy7", 32'(if_a.o_busy_regs[7]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", if_a.o_busy_regs, 32'd0);
      check("arst_cnt_a", 32'(if_a.o_stall_count), 32'd0);
      check("arst_cnt_b", 32'(if_b.o_stall_count), 32'd0);
      check("arst_ctl", 32'(ctl_a), 32'(CTL_STALL));
      model_reset();
      cur = idle_in();
      drive();
      @(negedge clk);
      rst_n = 1'b1;

      // ---- randomized cycles against the model ----
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         cur.rs1      = 5'($urandom_range(0, 7));
         cur.rs2      = 5'($urandom_range(0, 7));
         cur.rd       = 5'($urandom_range(0, 7));
         cur.ex_rd    = 5'($urandom_range(0, 7));
         cur.wb_rd    = 5'($urandom_range(0, 7));
         cur.u1       = 1'($urandom_range(0, 1));
         cur.u2       = 1'($urandom_range(0, 1));
         cur.is_long  = ($urandom_range(0, 3) == 0);
         cur.mem_read = ($urandom_range(0, 3) == 0);
         cur.issue    = ($urandom_range(0, 2) == 0);
         cur.wb       = ($urandom_range(0, 2) == 0);
         cur.br       = ($urandom_range(0, 9) == 0);
         cur.clr      = ($urandom_range(0, 29) == 0);
         begin_cycle();
         end_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
